// File: rtl/demux8w32_buf.sv
// Result demultiplexer: steers one WIDTH-bit result into one of LANES one-entry lane buffers.
// Optional macro BROADCAST_EN adds in_bcast, which loads every lane from a single input beat.
module demux8w32_buf #(
  parameter int WIDTH = 32,
  parameter int LANES = 8,
  parameter int SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [WIDTH-1:0]       in_data,
`ifdef BROADCAST_EN
  input  logic                   in_bcast,
`endif
  output logic [LANES-1:0]       lane_valid,
  input  logic [LANES-1:0]       lane_ready,
  output logic [LANES*WIDTH-1:0] lane_data,
  output logic                   drop_pulse,
  output logic [7:0]             drop_cnt
);

  // Handshake: a beat moves on a rising edge exactly when valid & ready are both high at that
  // edge; valid never waits on ready, and a lane's valid/data hold steady until it transfers.

  localparam int NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0] LANES_L = (SEL_W+1)'(LANES);

  logic             in_range;
  logic             bcast_req;
  logic             accept;
  logic             drop;
  logic             all_free;
  logic [NSEL-1:0]  free_pad;
  logic [LANES-1:0] load;
  logic [WIDTH-1:0] data_q [LANES];

`ifdef BROADCAST_EN
  assign bcast_req = in_valid & in_bcast;
`else
  assign bcast_req = 1'b0;
`endif

  assign in_range = {1'b0, in_sel} < LANES_L;

  // Select slots beyond LANES read as free, so an out-of-range select is always ready.
  always_comb begin
    free_pad = '1;
    for (int i = 0; i < LANES; i++) begin
      free_pad[i] = ~lane_valid[i] | lane_ready[i];
    end
  end

  assign all_free = &free_pad;
  assign in_ready = bcast_req ? all_free : free_pad[in_sel];
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~bcast_req & ~in_range;

  always_comb begin
    load = '0;
    for (int i = 0; i < LANES; i++) begin
      load[i] = accept & (bcast_req | (in_sel == SEL_W'(i)));
    end
  end

  // A load on the same edge as a drain wins, keeping one transfer per cycle per lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_valid <= '0;
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= '0;
      end
      drop_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load[i]) begin
          lane_valid[i] <= 1'b1;
          data_q[i]     <= in_data;
        end else if (lane_ready[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end
      drop_pulse <= drop;
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

endmodule
